// File: rtl/mul_hilo_seq.sv
// mul_hilo_seq: sequencer and HI/LO register stage around the mul_32 multiplier.
//
// A start request in IDLE captures op_a/op_b onto mul_a/mul_b. They stay
// constant while the multiplier settles for MUL_LATENCY cycles. The 64-bit
// product is then loaded into the architectural HI/LO registers and done
// pulses for one cycle. MTHI/MTLO writes are accepted only in IDLE. While a
// multiply is in flight, a pipeline request that touches HI/LO raises stall.
//
// Optional build macro: MUL_OVF_EN adds the ovf output (product does not fit
// in 32 signed bits).
//
// Ports:
//   clock            rising-edge clock
//   clear            asynchronous reset, active low
//   start            multiply request, honoured only in IDLE
//   op_a, op_b       signed operands
//   mul_a, mul_b     held operands driven to mul_32
//   mul_hi, mul_lo   product returned by mul_32
//   hi_in, hi_we     MTHI data / enable
//   lo_in, lo_we     MTLO data / enable
//   rd_req           MFHI/MFLO read in decode
//   hi_out, lo_out   architectural HI / LO
//   busy             multiply in flight
//   done             one-cycle pulse after HI/LO load from product
//   stall            pipeline hold request
//   ovf              (MUL_OVF_EN only) product overflowed 32 signed bits
//
// CNT_W must satisfy 2**CNT_W > MUL_LATENCY so the terminal count is reachable.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; MTHI/MTLO writes accepted
// RUN     | operands held, counting the multiplier settling interval
// CAPTURE | product valid; HI/LO load on the next edge

module mul_hilo_seq #(
    parameter int MUL_LATENCY = 34,
    parameter int CNT_W       = 6
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic [31:0] hi_in,
    input  logic        hi_we,
    input  logic [31:0] lo_in,
    input  logic        lo_we,
    input  logic        rd_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        stall
`ifdef MUL_OVF_EN
   ,output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             last_cycle;

    assign last_cycle = (count == CNT_W'(MUL_LATENCY - 1));

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_cycle) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy  = (state != IDLE);
        stall = busy & (rd_req | hi_we | lo_we);
    end

    // Datapath: operand hold, settling counter, HI/LO registers.
    // A write that coincides with an accepted start lands now and is simply
    // overwritten by the product at capture.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            hi_out <= '0;
            lo_out <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mul_a <= op_a;
                        mul_b <= op_b;
                        count <= '0;
                    end
                    if (hi_we) hi_out <= hi_in;
                    if (lo_we) lo_out <= lo_in;
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                end
                CAPTURE: begin
                    hi_out <= mul_hi;
                    lo_out <= mul_lo;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_OVF_EN
    // Product fits in 32 signed bits only if HI is the sign extension of LO.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start | hi_we | lo_we) ovf <= 1'b0;
                CAPTURE: ovf <= (mul_hi != {32{mul_lo[31]}});
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mul_hilo_seq.sv
module tb_mul_hilo_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] op_a, op_b;
    logic [31:0] mul_a, mul_b;
    logic [31:0] mul_hi, mul_lo;
    logic [31:0] hi_in, lo_in;
    logic        hi_we, lo_we, rd_req;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, stall;
`ifdef MUL_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // combinational mul_32 model
    logic signed [63:0] prod;
    assign prod   = 64'($signed(mul_a)) * 64'($signed(mul_b));
    assign mul_hi = prod[63:32];
    assign mul_lo = prod[31:0];

    always #5 clock = ~clock;

    mul_hilo_seq #(.MUL_LATENCY(34), .CNT_W(6)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_hi(mul_hi),
        .mul_lo(mul_lo),
        .hi_in (hi_in),
        .hi_we (hi_we),
        .lo_in (lo_in),
        .lo_we (lo_we),
        .rd_req(rd_req),
        .hi_out(hi_out),
        .lo_out(lo_out),
        .busy  (busy),
        .done  (done),
        .stall (stall)
`ifdef MUL_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Waits for done; lat = edges after t0 when done seen; nbusy = busy samples before done.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        if (busy) nbusy++;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (!done && busy) nbusy++;
        end
    endtask

    // Starts a multiply; returns with sampling just after the done edge.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int nbusy);
        @(posedge clock); #1;
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat, nbusy);
    endtask

    initial begin
        int lat, nbusy, ndone, nstall;
        logic [31:0] hold_hi;
        logic hi_bad;

        vecs[0] = '{"3x4",         32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0};
        vecs[1] = '{"m2x5",        32'hFFFFFFFE, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};
        vecs[2] = '{"4000_0000x4", 32'h40000000, 32'h00000004, 32'h00000001, 32'h00000000, 1'b1};
        vecs[3] = '{"maxpos_sq",   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1};
        vecs[4] = '{"m1xm1",       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5] = '{"minneg_sq",   32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
        vecs[6] = '{"minneg_x1",   32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};

        clear = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        hi_in = '0; lo_in = '0; hi_we = 1'b0; lo_we = 1'b0; rd_req = 1'b0;
        #1;
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_hi",     64'(hi_out), 64'd0);
        chk("rst_lo",     64'(lo_out), 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        #11 clear = 1'b1;

        // table-driven multiplies
        for (int i = 0; i < 7; i++) begin
            run_mul(vecs[i].a, vecs[i].b, lat, nbusy);
            chk({vecs[i].name, "_latency"}, 64'(lat),   64'd35);
            chk({vecs[i].name, "_busycyc"}, 64'(nbusy), 64'd35);
            chk({vecs[i].name, "_hi"},      64'(hi_out), 64'(vecs[i].hi));
            chk({vecs[i].name, "_lo"},      64'(lo_out), 64'(vecs[i].lo));
            chk({vecs[i].name, "_idle"},    64'(busy),   64'd0);
`ifdef MUL_OVF_EN
            chk({vecs[i].name, "_ovf"},     64'(ovf),    64'(vecs[i].ov));
`endif
            @(posedge clock); #1;
            chk({vecs[i].name, "_done1cyc"}, 64'(done), 64'd0);
        end

        // MTHI then MTLO in IDLE
        @(posedge clock); #1;
        hi_we = 1'b1; hi_in = 32'h12345678;
        #1 chk("idle_stall_hi", 64'(stall), 64'd0);
        @(posedge clock); #1;
        hi_we = 1'b0;
        chk("idle_hi_wr",   64'(hi_out), 64'h12345678);
        chk("idle_lo_keep", 64'(lo_out), 64'h80000000);
        lo_we = 1'b1; lo_in = 32'h9ABCDEF0;
        #1 chk("idle_stall_lo", 64'(stall), 64'd0);
        @(posedge clock); #1;
        lo_we = 1'b0;
        chk("idle_lo_wr",   64'(lo_out), 64'h9ABCDEF0);
        chk("idle_hi_keep", 64'(hi_out), 64'h12345678);
`ifdef MUL_OVF_EN
        chk("idle_wr_ovf_clr", 64'(ovf), 64'd0);
`endif

        // stall during RUN with rd_req and a dropped MTHI
        hold_hi = hi_out;
        hi_bad = 1'b0;
        nstall = 0;
        @(posedge clock); #1;
        op_a = 32'hFFFFFFFE; op_b = 32'h00000005; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        rd_req = 1'b1; hi_we = 1'b1; hi_in = 32'h0000DEAD;
        #1;
        lat = 0;
        while (!done && lat < 100) begin
            if (busy && stall) nstall++;
            if (hi_out !== hold_hi) hi_bad = 1'b1;
            @(posedge clock); #2;
            lat++;
        end
        chk("stall_cycles", 64'(nstall), 64'd35);
        chk("stall_hi_held", 64'(hi_bad), 64'd0);
        chk("stall_after_done", 64'(stall), 64'd0);
        chk("stall_hi_prod", 64'(hi_out), 64'hFFFFFFFF);
        rd_req = 1'b0; hi_we = 1'b0;
        @(posedge clock); #1;
        chk("stall_hi_final", 64'(hi_out), 64'hFFFFFFFF);

        // second start 5 cycles in is ignored
        @(posedge clock); #1;
        op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ign_mul_a", 64'(mul_a), 64'd7);
        chk("ign_mul_b", 64'(mul_b), 64'd6);
        ndone = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_result", {hi_out, lo_out}, 64'd42);
        chk("ign_mul_a_idle", 64'(mul_a), 64'd7);

        // MTHI together with start: written, then overwritten at capture
        @(posedge clock); #1;
        op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        hi_we = 1'b1; hi_in = 32'hAAAA5555;
        @(posedge clock); #1;
        start = 1'b0; hi_we = 1'b0;
        chk("wrst_hi_now", 64'(hi_out), 64'hAAAA5555);
        wait_done(lat, nbusy);
        chk("wrst_lat", 64'(lat), 64'd35);
        chk("wrst_result", {hi_out, lo_out}, 64'd6);

        // reset mid-multiply
        @(posedge clock); #1;
        op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1 clear = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_hilo", {hi_out, lo_out}, 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        #2 clear = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("mrst_no_done", 64'(ndone), 64'd0);
        run_mul(32'd5, 32'd5, lat, nbusy);
        chk("mrst_after_lat", 64'(lat), 64'd35);
        chk("mrst_after_res", {hi_out, lo_out}, 64'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_hilo_seq.md
Name: mul_hilo_seq

Overview:
Sequencer and HI/LO register stage around the mul_32 multiplier. Captures operands on a start request and holds them stable on the multiplier inputs. Waits a fixed settling interval, then loads the 64-bit product into the architectural HI/LO registers. Serves MFHI/MFLO reads and MTHI/MTLO writes, stalling the pipeline while a multiply is in flight.

Parameters:
MUL_LATENCY, 34, cycles operands are held before the product is sampled (>=1)
CNT_W, 6, width of the latency counter; must satisfy 2**CNT_W > MUL_LATENCY

Ports:
clock  in  1  single clock, rising edge
clear  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  request multiply of op_a*op_b; sampled only in IDLE
op_a  in  32  signed multiplicand
op_b  in  32  signed multiplier
mul_a  out  32  held operand to mul_32 A
mul_b  out  32  held operand to mul_32 B
mul_hi  in  32  mul_32 HI result
mul_lo  in  32  mul_32 LO result
hi_in  in  32  MTHI data
hi_we  in  1  MTHI write enable
lo_in  in  32  MTLO data
lo_we  in  1  MTLO write enable
rd_req  in  1  MFHI/MFLO read in decode
hi_out  out  32  architectural HI
lo_out  out  32  architectural LO
busy  out  1  multiply in flight
done  out  1  one-cycle pulse: HI/LO just loaded from product
stall  out  1  pipeline hold request

Behaviour:
- Reset (clear=0, async): state=IDLE, count=0, mul_a=mul_b=hi_out=lo_out=0, done=0.
- States: IDLE, RUN, CAPTURE. busy = (state != IDLE), registered-state decode.
- IDLE: start=1 at edge t0 -> mul_a<=op_a, mul_b<=op_b, count<=0, state<=RUN.
- RUN: count increments each edge; at the edge where count==MUL_LATENCY-1 -> CAPTURE. mul_a/mul_b are held constant.
- CAPTURE: next edge -> hi_out<=mul_hi, lo_out<=mul_lo, done<=1, state<=IDLE.
- Timing: start sampled at edge t0. CAPTURE is entered at t0+MUL_LATENCY. HI/LO and done are visible after edge t0+MUL_LATENCY+1. done is high for exactly one cycle.
- start while busy: ignored, no queuing.
- hi_we/lo_we in IDLE: write at the edge, independent of each other.
- hi_we/lo_we together with start in IDLE: the write is applied, then overwritten at capture.
- hi_we/lo_we while busy: dropped. stall = busy & (rd_req | hi_we | lo_we), combinational.
- The upstream pipeline re-presents the stalled instruction until stall=0.
- mul_a/mul_b keep their last values in IDLE.
- Reset mid-operation: returns to IDLE immediately. No done is generated. hi_out/lo_out are zeroed.

Optional Feature:
MUL_OVF_EN: adds output port ovf (1 bit). ovf is registered with done and set when the product does not fit in 32 signed bits: mul_hi != {32{mul_lo[31]}}. ovf is cleared on reset, on the next start, and on any MTHI/MTLO write. Without the macro, the port and logic are absent.

Test Plan:
- Bench models mul_32 as a combinational {mul_hi,mul_lo}=mul_a*mul_b, MUL_LATENCY=34. op_a=3, op_b=4, start pulse at t0 -> busy for 35 cycles, done after edge t0+35, hi_out=0, lo_out=0x0000000C.
- op_a=-2, op_b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF6. With MUL_OVF_EN: ovf=0. Then 0x40000000*4 -> hi_out=1, lo_out=0, ovf=1.
- Second start 5 cycles into a multiply, with different operands -> ignored; mul_a/mul_b unchanged; exactly one done pulse; result matches the first operands.
- rd_req=1 and hi_we=1 (hi_in=0xDEAD) during RUN -> stall=1 each busy cycle; HI not written; stall=0 the cycle after done.
- In IDLE: hi_we, hi_in=0x12345678, then lo_we, lo_in=0x9ABCDEF0 -> hi_out/lo_out updated after each edge; stall=0.
- clear=0 at t0+10 mid-multiply -> immediately busy=0, hi_out=lo_out=0, no done. A subsequent start completes normally.
